cpu_fetch_unit: RTL and testbench
=================================

// Module: cpu_fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the CPU execution unit.
//  - Holds the PC and fetches from instruction memory over a req/ready handshake.
//  - Latches the instruction into IR and presents IR to the EU and the control unit.
//  - Computes the next PC (sequential, branch or jump) when execution completes.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; must be word-aligned
//  TIMEOUT    16             max cycles in FETCH without imem_ready before error
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  imem_req     out  1   instruction memory request, high only in FETCH
//  imem_addr    out  32  fetch address; equals PC
//  imem_ready   in   1   memory has valid imem_rdata this cycle
//  imem_rdata   in   32  instruction word from memory
//  exec_done    in   1   EU/control finished current instruction; sampled only in EXEC
//  branch       in   1   current instruction is a conditional branch (beq)
//  zero         in   1   EU Zero flag
//  jump         in   1   current instruction is a jump (j)
//  se_imm       in   32  EU sign-extended immediate
//  instruction  out  32  IR; [31:26] go to control, [25:0] go to EU
//  instr_valid  out  1   IR holds a fetched instruction awaiting execution
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4, combinational
//  fetch_err    out  1   sticky fetch timeout flag
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pc=RESET_PC, instruction=0, instr_valid=0, fetch_err=0.
//  - State=FETCH, timeout counter=0.
//  - imem_req=0 while rst_n is low.
//  States FETCH, EXEC, ERR:
//  - Outputs: imem_req = (state==FETCH) & rst_n. instr_valid = (state==EXEC).
//  - FETCH, imem_ready=1: IR<=imem_rdata, counter<=0, next state EXEC.
//  - FETCH, imem_ready=0: counter++. When counter reaches TIMEOUT-1 with no ready,
//    next state ERR.
//  - EXEC: hold IR and pc. On exec_done=1, pc<=next_pc, next state FETCH.
//  - ERR: fetch_err=1, imem_req=0, instr_valid=0. Absorbing; exited only by reset.
//  Next-PC rules (all arithmetic modulo 2^32):
//  - Priority: jump > branch.
//  - jump=1: next_pc = {pc_plus4[31:28], IR[25:0], 2'b00}.
//  - branch&zero: next_pc = pc_plus4 + (se_imm << 2).
//  - Otherwise: next_pc = pc_plus4.
//  Ignored inputs:
//  - imem_ready outside FETCH. exec_done, branch, zero, jump, se_imm outside EXEC.
//  Timing and boundary conditions:
//  - Latency: ready in the first FETCH cycle puts IR valid on the next cycle.
//    Minimum 2 cycles per instruction (FETCH, EXEC).
//  - imem_rdata is sampled only in the cycle where imem_ready=1.
//  - pc=32'hFFFF_FFFC with sequential flow wraps to 0.
//  - Reset mid-fetch or mid-exec: abort immediately, no pc update.
//  - imem_ready and the timeout threshold in the same cycle: ready wins (go EXEC).
// TESTING
//  - Reset, RESET_PC=0, imem_ready=1 every cycle:
//    imem_addr sequence 0,4,8 with exec_done=1 each EXEC; instruction matches imem_rdata.
//  - pc=0x40, IR present, branch=1, zero=1, se_imm=0xFFFF_FFFE:
//    next imem_addr = 0x44-8 = 0x3C. Repeat with zero=0 -> 0x44.
//  - pc=0x1000_0000, IR[25:0]=0x0000100, jump=1, branch=1, zero=1:
//    next imem_addr = 0x1000_0400 (jump wins).
//  - TIMEOUT=4, imem_ready held 0: fetch_err=1 after 4 FETCH cycles;
//    imem_req=0 afterwards; ready later has no effect; rst_n pulse clears.
//  - Assert rst_n=0 in EXEC at pc=0x20:
//    pc=RESET_PC, instr_valid=0 immediately (async); fetch restarts at RESET_PC.
//  - pc=0xFFFF_FFFC, sequential exec_done: next imem_addr=0x0000_0000;
//    imem_ready asserted during EXEC is ignored.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake,
// holds the instruction in IR during execution and selects the next PC.
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] se_imm,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, ir_q, next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    // Jump takes priority over a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        else if (branch && zero)
            next_pc = pc_plus4 + (se_imm << 2);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXEC:    if (exec_done) state_d = FETCH;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == FETCH && imem_ready) ir_q <= imem_rdata;
            if (state_q == EXEC && exec_done)   pc_q <= next_pc;
        end
    end

    // Request is gated by reset so it drops the instant rst_n falls.
    assign imem_req    = (state_q == FETCH) & rst_n;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign instr_valid = (state_q == EXEC);
    assign fetch_err   = (state_q == ERR);
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboarded bench for cpu_fetch_unit: fetched words are queued when
// driven and compared when the unit presents them as a valid IR.
module tb_cpu_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        exec_done = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic [31:0] se_imm = '0;
    logic [31:0] instruction, pc, pc_plus4;
    logic        instr_valid, fetch_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ir;

    always #5 clk = ~clk;

    cpu_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .exec_done(exec_done),
        .branch(branch), .zero(zero), .jump(jump), .se_imm(se_imm),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    // Stimulus helpers: callers sit 1 time unit after a rising edge.
    task automatic do_fetch(input logic [31:0] d, output logic [31:0] addr_seen);
        addr_seen  = imem_addr;
        imem_ready = 1'b1;
        imem_rdata = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic do_exec(input logic j, input logic b, input logic z,
                           input logic [31:0] imm, input logic rdy);
        exec_done = 1'b1; jump = j; branch = b; zero = z; se_imm = imm;
        imem_ready = rdy; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        exec_done = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0; se_imm = '0;
        imem_ready = 1'b0; imem_rdata = '0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: IR valid with nothing queued");
            exp_ir = 'x;
        end else begin
            exp_ir = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
        n_checks++; if (instruction !== 32'h0) $display("FAIL rst_ir: got %h want 0", instruction); else n_pass++;
        n_checks++; if ({instr_valid, fetch_err} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {instr_valid, fetch_err}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rst_release_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (pc_plus4 !== 32'h4) $display("FAIL rst_pc_plus4: got %h want 4", pc_plus4); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic [31:0] want [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b1) $display("FAIL seq_req%0d: got %b want 1", i, imem_req); else n_pass++;
            do_fetch(32'h2000_0000 | $urandom_range(0, 32'hFFFF), a);
            n_checks++; if (a !== want[i]) $display("FAIL seq_addr%0d: got %h want %h", i, a, want[i]); else n_pass++;
            pop_exp();
            n_checks++; if (instr_valid !== 1'b1 || instruction !== exp_ir)
                $display("FAIL seq_ir%0d: got v=%b %h want v=1 %h", i, instr_valid, instruction, exp_ir); else n_pass++;
            n_checks++; if (imem_req !== 1'b0) $display("FAIL seq_req_exec%0d: got %b want 0", i, imem_req); else n_pass++;
            do_exec(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            n_checks++; if (instruction !== exp_ir) $display("FAIL seq_hold%0d: got %h want %h", i, instruction, exp_ir); else n_pass++;
        end
        n_checks++; if (imem_addr !== 32'hC) $display("FAIL seq_final: got %h want c", imem_addr); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] a;
        do_fetch(32'h0800_0010, a); pop_exp();   // j to 0x40
        do_exec(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (imem_addr !== 32'h40) $display("FAIL br_setup: got %h want 40", imem_addr); else n_pass++;
        do_fetch(32'h1000_FFFE, a); pop_exp();
        n_checks++; if (instruction !== exp_ir) $display("FAIL br_ir: got %h want %h", instruction, exp_ir); else n_pass++;
        do_exec(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        n_checks++; if (imem_addr !== 32'h3C) $display("FAIL br_taken: got %h want 3c", imem_addr); else n_pass++;
        do_fetch(32'h0800_0010, a); pop_exp();
        do_exec(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h1000_FFFE, a); pop_exp();
        n_checks++; if (a !== 32'h40) $display("FAIL br_refetch: got %h want 40", a); else n_pass++;
        do_exec(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
        n_checks++; if (imem_addr !== 32'h44) $display("FAIL br_not_taken: got %h want 44", imem_addr); else n_pass++;
    endtask

    task automatic test_jump();
        logic [31:0] a;
        do_fetch(32'h1000_0000, a); pop_exp();   // branch 0x44 -> 0x1000_0000
        do_exec(1'b0, 1'b1, 1'b1, 32'h03FF_FFEE, 1'b0);
        n_checks++; if (imem_addr !== 32'h1000_0000) $display("FAIL jmp_setup: got %h want 10000000", imem_addr); else n_pass++;
        do_fetch(32'h0800_0100, a); pop_exp();
        n_checks++; if (instruction !== exp_ir) $display("FAIL jmp_ir: got %h want %h", instruction, exp_ir); else n_pass++;
        do_exec(1'b1, 1'b1, 1'b1, 32'h0000_0055, 1'b0);
        n_checks++; if (imem_addr !== 32'h1000_0400) $display("FAIL jmp_priority: got %h want 10000400", imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        do_fetch(32'h1000_0000, a); pop_exp();   // branch 0x1000_0400 -> 0xFFFF_FFFC
        do_exec(1'b0, 1'b1, 1'b1, 32'h3BFF_FEFE, 1'b0);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want fffffffc", imem_addr); else n_pass++;
        do_fetch(32'h0123_4567, a); pop_exp();
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instruction !== exp_ir)
            $display("FAIL wrap_ready_ignored: got v=%b %h want v=1 %h", instr_valid, instruction, exp_ir); else n_pass++;
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", imem_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] a;
        do_fetch(32'h0800_0008, a); pop_exp();   // j to 0x20
        do_exec(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h0000_7777, a); pop_exp();
        n_checks++; if (pc !== 32'h20 || instr_valid !== 1'b1) $display("FAIL rme_setup: got pc=%h v=%b want 20 1", pc, instr_valid); else n_pass++;
        exec_done = 1'b1; jump = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL rme_async: got pc=%h v=%b req=%b want 0 0 0", pc, instr_valid, imem_req); else n_pass++;
        @(posedge clk); #1;
        exec_done = 1'b0; jump = 1'b0;
        n_checks++; if (pc !== 32'h0) $display("FAIL rme_no_update: got %h want 0", pc); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_fetch(32'h3C01_0042, a); pop_exp();
        n_checks++; if (a !== 32'h0 || instruction !== exp_ir)
            $display("FAIL rme_restart: got addr=%h ir=%h want 0 %h", a, instruction, exp_ir); else n_pass++;
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fetch_err !== 1'b0) $display("FAIL to_pre_edge: got %b want 0", fetch_err); else n_pass++;
        do_fetch(32'h0ABC_DEF0, a); pop_exp();   // ready on the threshold cycle
        n_checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0 || instruction !== exp_ir)
            $display("FAIL to_ready_wins: got v=%b err=%b ir=%h want 1 0 %h", instr_valid, fetch_err, instruction, exp_ir); else n_pass++;
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) $display("FAIL to_3cyc: got err=%b req=%b want 0 1", fetch_err, imem_req); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL to_err: got err=%b req=%b v=%b want 1 0 0", fetch_err, imem_req, instr_valid); else n_pass++;
        imem_ready = 1'b1; imem_rdata = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1;
        imem_ready = 1'b0;
        n_checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || instruction !== exp_ir)
            $display("FAIL to_sticky: got err=%b v=%b ir=%h want 1 0 %h", fetch_err, instr_valid, instruction, exp_ir); else n_pass++;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL to_reset_clear: got err=%b req=%b addr=%h want 0 1 0", fetch_err, imem_req, imem_addr); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_reset_mid_exec();
        test_timeout();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
